led_matrix_scanner: RTL and testbench



---
 rtl/led_matrix_scanner_pkg.sv | 19 +
 rtl/led_matrix_scanner_if.sv | 27 ++
 rtl/led_matrix_scanner_scan_timer.sv | 26 ++
 rtl/led_matrix_scanner.sv | 135 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scanner_pkg.sv
// Shared constants and scan FSM states for the LED matrix scanner and its renderer.
// Optional brightness PWM is enabled by defining LED_SCAN_BRIGHTNESS_PWM_EN.
package led_matrix_scanner_pkg;

  localparam int WIDTH        = 16;
  localparam int BIT_OF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DISPLAY,
    BLANK
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Row interface between the scanner (master) and the renderer / LED panel (slave).
interface led_matrix_scanner_if;
  import led_matrix_scanner_pkg::*;

  logic [BIT_OF_WIDTH-1:0] count;
  logic [WIDTH-1:0]        row_data;
  logic [WIDTH-1:0]        row_sel;
  logic [WIDTH-1:0]        col_out;
  logic                    frame_start;

  modport master (
    output count,
    output row_sel,
    output col_out,
    output frame_start,
    input  row_data
  );

  modport slave (
    input  count,
    input  row_sel,
    input  col_out,
    input  frame_start,
    output row_data
  );

endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Loadable down-counter shared by the DISPLAY and BLANK phases; o_done flags the last cycle.
module scan_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_done
);

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_load) begin
      r_timer <= i_load_val;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - TW'(1);
    end
  end

  assign o_done = (r_timer == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scan driver for the 16x16 LED matrix: latches one row word per row and drives it with blanking.
// Define LED_SCAN_BRIGHTNESS_PWM_EN to add the 4-bit brightness input and in-row PWM gating.
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
  input  logic [3:0]           brightness,
`endif
  led_matrix_scanner_if.master bus
);

  localparam int TIMER_W = $clog2(max_int(SCAN_DIV, BLANK_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] DISPLAY_LOAD = TIMER_W'(SCAN_DIV - 1);
  localparam logic [TIMER_W-1:0] BLANK_LOAD   = TIMER_W'(BLANK_CYCLES - 1);

  scan_state_t             r_state;
  logic [BIT_OF_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]        r_row_sel;
  logic [WIDTH-1:0]        r_col_out;
  logic [WIDTH-1:0]        r_col_reg;
  logic                    r_frame_start;

  logic                    w_done;
  logic                    w_load;
  logic                    w_latch;
  logic [TIMER_W-1:0]      w_load_val;
  logic [WIDTH-1:0]        w_row_onehot;
  logic                    w_lit_entry;
  logic                    w_lit_stay;

  assign w_row_onehot = WIDTH'(1) << r_count;

  // Row data is sampled only when a DISPLAY phase is about to begin.
  assign w_latch    = enable && ((r_state == SETUP) || ((r_state == BLANK) && w_done));
  assign w_load     = !enable || w_latch || ((r_state == DISPLAY) && w_done);
  assign w_load_val = !enable                ? '0 :
                      (r_state == DISPLAY)   ? BLANK_LOAD :
                                               DISPLAY_LOAD;

  scan_timer #(
    .TW(TIMER_W)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] r_brightness;
  logic [3:0] r_phase;
  logic [3:0] w_next_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brightness <= '0;
      r_phase      <= '0;
    end else if (w_latch) begin
      r_brightness <= brightness;
      r_phase      <= '0;
    end else if (r_state == DISPLAY) begin
      r_phase <= w_next_phase;
    end
  end

  // The phase wraps mod 16, so the gate repeats every 16 DISPLAY cycles.
  assign w_next_phase = r_phase + 4'd1;
  assign w_lit_entry  = (brightness != 4'd0);
  assign w_lit_stay   = (r_brightness == 4'hF) || (w_next_phase < r_brightness);
`else
  assign w_lit_entry = 1'b1;
  assign w_lit_stay  = 1'b1;
`endif

  // Outputs are computed for the next cycle so row_sel and col_out always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_row_sel     <= '0;
      r_col_out     <= '0;
      r_col_reg     <= '0;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_row_sel     <= '0;
      r_col_out     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= SETUP;
        end
        SETUP, BLANK: begin
          if (w_latch) begin
            r_state       <= DISPLAY;
            r_col_reg     <= bus.row_data;
            r_row_sel     <= w_lit_entry ? w_row_onehot : '0;
            r_col_out     <= w_lit_entry ? bus.row_data : '0;
            r_frame_start <= (r_count == '0);
          end
        end
        DISPLAY: begin
          if (w_done) begin
            r_state   <= BLANK;
            r_count   <= r_count + BIT_OF_WIDTH'(1);
            r_row_sel <= '0;
            r_col_out <= '0;
          end else begin
            r_row_sel <= w_lit_stay ? w_row_onehot : '0;
            r_col_out <= w_lit_stay ? r_col_reg : '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.count       = r_count;
  assign bus.row_sel     = r_row_sel;
  assign bus.col_out     = r_col_out;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a timeline model predicts every cycle's outputs.
// Build with LED_SCAN_BRIGHTNESS_PWM_EN defined to also exercise the brightness input.
module tb_led_matrix_scanner;
  import led_matrix_scanner_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int ROW_PERIOD   = SCAN_DIV + BLANK_CYCLES;
  localparam int FRAME        = WIDTH * ROW_PERIOD;

  typedef struct packed {
    logic [WIDTH-1:0]        rowSel;
    logic [WIDTH-1:0]        colOut;
    logic [BIT_OF_WIDTH-1:0] count;
    logic                    frameStart;
  } expect_t;

  logic clk;
  logic rst_n;
  logic enable;
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] brightness;
`endif
  logic [WIDTH-1:0] rowTable [WIDTH];

  int testsRun = 0;
  int failed   = 0;
  int cycle    = 0;

  expect_t expQ[$];
  int      frameCycles[$];

  // Model state: a row timeline measured from the first DISPLAY cycle after SETUP.
  bit                      mActive    = 1'b0;
  bit                      mInDisplay = 1'b0;
  int                      mK         = 0;
  int                      mRow       = 0;
  logic [BIT_OF_WIDTH-1:0] mCount     = '0;
  logic [WIDTH-1:0]        mLatched   = '0;
  logic [3:0]              mBright    = 4'hF;

  led_matrix_scanner_if bus ();

  assign bus.row_data = rowTable[bus.count];

  led_matrix_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
    .brightness (brightness),
`endif
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit pwmOn(input int elapsed, input logic [3:0] b);
    return (b == 4'hF) || ((elapsed % 16) < int'(b));
  endfunction

  task automatic checkOutput(input string name, input expect_t e);
    testsRun++;
    if (bus.row_sel !== e.rowSel || bus.col_out !== e.colOut ||
        bus.count !== e.count || bus.frame_start !== e.frameStart) begin
      failed++;
      $display("[TB] FAIL %s cycle %0d: row_sel=%h/%h col_out=%h/%h count=%0d/%0d frame_start=%b/%b (actual/required)",
               name, cycle, bus.row_sel, e.rowSel, bus.col_out, e.colOut,
               bus.count, e.count, bus.frame_start, e.frameStart);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Reference model: predicts the outputs of the cycle that starts at each rising edge.
  always @(posedge clk) begin
    expect_t e;
    int      ph;
    cycle++;
    e = '0;
    if (!rst_n || !enable) begin
      mActive    = 1'b0;
      mInDisplay = 1'b0;
      mCount     = '0;
    end else if (!mActive) begin
      mActive    = 1'b1;
      mInDisplay = 1'b0;
      mK         = -1;
      mCount     = '0;
    end else begin
      mK++;
      mRow = (mK / ROW_PERIOD) % WIDTH;
      ph   = mK % ROW_PERIOD;
      if (ph == 0) begin
        mLatched = rowTable[mCount];
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
        mBright = brightness;
`else
        mBright = 4'hF;
`endif
      end
      if (ph < SCAN_DIV) begin
        mInDisplay   = 1'b1;
        mCount       = BIT_OF_WIDTH'(mRow);
        e.frameStart = (mRow == 0) && (ph == 0);
        if (pwmOn(ph, mBright)) begin
          e.rowSel = WIDTH'(1) << mRow;
          e.colOut = mLatched;
        end
      end else begin
        mInDisplay = 1'b0;
        mCount     = BIT_OF_WIDTH'((mRow + 1) % WIDTH);
      end
    end
    e.count = mCount;
    expQ.push_back(e);
  end

  // Monitor: compares the DUT against the oldest prediction once per cycle.
  always @(negedge clk) begin
    expect_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("scoreboard", e);
    end
    if (bus.frame_start === 1'b1) frameCycles.push_back(cycle);
  end

  task automatic applyStimulus(input int cycles, input int dropOdds, input bit mutate);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #2;
      if (mutate && $urandom_range(0, 3) == 0)
        rowTable[$urandom_range(0, WIDTH - 1)] = WIDTH'($urandom);
      if (dropOdds > 0) begin
        if (!enable && $urandom_range(0, 1) == 0) enable = 1'b1;
        else if (enable && $urandom_range(1, dropOdds) == 1) enable = 1'b0;
      end
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
      if (mutate && $urandom_range(0, 7) == 0) brightness = 4'($urandom_range(0, 15));
`endif
    end
  endtask

  initial begin
    bit found;
    rst_n  = 1'b0;
    enable = 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
    brightness = 4'hF;
`endif
    for (int i = 0; i < WIDTH; i++) rowTable[i] = WIDTH'(i);

    #2;
    checkOutput("reset_state", '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Continuous scan with the renderer returning its own row index.
    @(negedge clk);
    #2 enable = 1'b1;
    frameCycles.delete();
    applyStimulus(2 * FRAME + 10, 0, 1'b0);
    checkValue("frame_starts_seen", int'(frameCycles.size() >= 2), 1);
    if (frameCycles.size() >= 2)
      checkValue("frame_period", frameCycles[1] - frameCycles[0], FRAME);

    // Random row data changes mid-row, random enable drops.
    applyStimulus(600, 40, 1'b1);

    // Drop enable during row 5, then restart from row 0.
    enable = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 3 * FRAME && !found; c++) begin
      @(negedge clk);
      #2;
      if (mInDisplay && mRow == 5) found = 1'b1;
    end
    checkValue("row5_reached", int'(found), 1);
    enable = 1'b0;
    applyStimulus(3, 0, 1'b0);
    enable = 1'b1;
    applyStimulus(30, 0, 1'b1);

    // Asynchronous reset in the middle of a lit row.
`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
    brightness = 4'hF;
`endif
    found = 1'b0;
    for (int c = 0; c < 3 * FRAME && !found; c++) begin
      @(negedge clk);
      if (mInDisplay && (mK % ROW_PERIOD) == 1 && mRow >= 1) found = 1'b1;
    end
    checkValue("lit_row_reached", int'(found), 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset_dark", '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(40, 0, 1'b1);

`ifdef LED_SCAN_BRIGHTNESS_PWM_EN
    // Fixed partial brightness: only the first two DISPLAY cycles of each row are lit.
    brightness = 4'd2;
    applyStimulus(FRAME + 10, 0, 1'b0);
    brightness = 4'd0;
    applyStimulus(FRAME + 10, 0, 1'b0);
`endif

    applyStimulus(4, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
